wb_sram8_ctrl: RTL and testbench

Wishbone slave that sits directly downstream of the CPU Wishbone master and serves its memory-space cycles (wb_tga_i=0) from an external asynchronous 8-bit SRAM. Each 16-bit Wishbone access with byte selects is split into one or two SRAM byte phases, with a programmable wait-state count per phase. The block returns one registered single-cycle acknowledge per accepted cycle. I/O-space cycles are ignored and left to the I/O decoder.

---
 rtl/wb_sram8_ctrl.sv | 155 +++++++++++++++
 tb/tb_wb_sram8_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram8_ctrl.sv
// Wishbone slave serving 16-bit memory-space cycles from an 8-bit asynchronous SRAM.
// Each access is split into up to two byte phases of WAIT_CYC+1 clocks each.
module wb_sram8_ctrl #(
   parameter int WAIT_CYC = 2
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   input  logic [19:1] wb_adr_i,
   input  logic        wb_we_i,
   input  logic        wb_tga_i,
   input  logic [1:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   output logic [19:0] sram_addr_o,
   input  logic [7:0]  sram_data_i,
   output logic [7:0]  sram_data_o,
   output logic        sram_data_oe,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_ACK
   } state_t;

   localparam logic [3:0] CNT_LAST   = 4'(WAIT_CYC);
   localparam logic [3:0] CNT_WE_END = 4'(WAIT_CYC - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [19:1] adr_q;
   logic        we_q;
   logic [1:0]  sel_q;
   logic [15:0] dat_q;
   logic        abort_q;

   logic        req;
   logic        abort_now;

   // Request qualification and abort detection (cyc may drop on the last phase clock).
   always_comb begin
      req       = wb_stb_i & wb_cyc_i & ~wb_tga_i;
      abort_now = abort_q | ~wb_cyc_i;
   end

   // Controller FSM; every SRAM strobe is set on phase entry so all outputs are flops.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         adr_q        <= '0;
         we_q         <= 1'b0;
         sel_q        <= '0;
         dat_q        <= '0;
         abort_q      <= 1'b0;
         wb_ack_o     <= 1'b0;
         wb_dat_o     <= '0;
         sram_addr_o  <= '0;
         sram_data_o  <= '0;
         sram_data_oe <= 1'b0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
      end else begin
         wb_ack_o <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (req) begin
                  adr_q    <= wb_adr_i;
                  we_q     <= wb_we_i;
                  sel_q    <= wb_sel_i;
                  dat_q    <= wb_dat_i;
                  abort_q  <= 1'b0;
                  wb_dat_o <= '0;
                  cnt_q    <= '0;
                  if (wb_sel_i[0]) begin
                     state_q      <= S_LO;
                     sram_addr_o  <= {wb_adr_i, 1'b0};
                     sram_data_o  <= wb_dat_i[7:0];
                     sram_ce_n    <= 1'b0;
                     sram_oe_n    <= wb_we_i;
                     sram_we_n    <= ~wb_we_i;
                     sram_data_oe <= wb_we_i;
                  end else if (wb_sel_i[1]) begin
                     state_q      <= S_HI;
                     sram_addr_o  <= {wb_adr_i, 1'b1};
                     sram_data_o  <= wb_dat_i[15:8];
                     sram_ce_n    <= 1'b0;
                     sram_oe_n    <= wb_we_i;
                     sram_we_n    <= ~wb_we_i;
                     sram_data_oe <= wb_we_i;
                  end else begin
                     state_q  <= S_ACK;
                     wb_ack_o <= 1'b1;
                  end
               end
            end

            S_LO, S_HI: begin
               if (!wb_cyc_i) begin
                  abort_q <= 1'b1;
               end
               if (cnt_q == CNT_LAST) begin
                  cnt_q <= '0;
                  if (!we_q) begin
                     if (state_q == S_LO) begin
                        wb_dat_o[7:0] <= sram_data_i;
                     end else begin
                        wb_dat_o[15:8] <= sram_data_i;
                     end
                  end
                  if (!abort_now && state_q == S_LO && sel_q[1]) begin
                     state_q      <= S_HI;
                     sram_addr_o  <= {adr_q, 1'b1};
                     sram_data_o  <= dat_q[15:8];
                     sram_ce_n    <= 1'b0;
                     sram_oe_n    <= we_q;
                     sram_we_n    <= ~we_q;
                     sram_data_oe <= we_q;
                  end else begin
                     state_q      <= abort_now ? S_IDLE : S_ACK;
                     wb_ack_o     <= ~abort_now;
                     sram_ce_n    <= 1'b1;
                     sram_oe_n    <= 1'b1;
                     sram_we_n    <= 1'b1;
                     sram_data_oe <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 4'd1;
                  // Release we_n one clock before the phase ends to give data hold time.
                  if (cnt_q == CNT_WE_END) begin
                     sram_we_n <= 1'b1;
                  end
               end
            end

            S_ACK: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_sram8_ctrl.sv
// Scoreboard bench for wb_sram8_ctrl: a driver pushes expected responses, a monitor
// pops them on every ack; an array-based memory model provides the reference data.
module tb_wb_sram8_ctrl;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic [19:1] wb_adr_i;
   logic        wb_we_i;
   logic        wb_tga_i;
   logic [1:0]  wb_sel_i;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_ack_o;
   logic [19:0] sram_addr_o;
   logic [7:0]  sram_data_i;
   logic [7:0]  sram_data_o;
   logic        sram_data_oe;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;

   always #5 clk = ~clk;

   wb_sram8_ctrl #(.WAIT_CYC(W)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .wb_dat_i    (wb_dat_i),
      .wb_dat_o    (wb_dat_o),
      .wb_adr_i    (wb_adr_i),
      .wb_we_i     (wb_we_i),
      .wb_tga_i    (wb_tga_i),
      .wb_sel_i    (wb_sel_i),
      .wb_stb_i    (wb_stb_i),
      .wb_cyc_i    (wb_cyc_i),
      .wb_ack_o    (wb_ack_o),
      .sram_addr_o (sram_addr_o),
      .sram_data_i (sram_data_i),
      .sram_data_o (sram_data_o),
      .sram_data_oe(sram_data_oe),
      .sram_ce_n   (sram_ce_n),
      .sram_oe_n   (sram_oe_n),
      .sram_we_n   (sram_we_n)
   );

   // ---------------- SRAM device model ----------------
   function automatic logic [7:0] init_byte(input logic [19:0] a);
      return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'hA5;
   endfunction

   bit [7:0] sram_mem [0:1048575];
   bit       sram_wr  [0:1048575];

   assign sram_data_i = (!sram_ce_n && !sram_oe_n)
                        ? (sram_wr[sram_addr_o] ? sram_mem[sram_addr_o] : init_byte(sram_addr_o))
                        : 8'hEE;

   always @(posedge sram_we_n) begin
      if (!sram_ce_n && sram_data_oe) begin
         sram_mem[sram_addr_o] = sram_data_o;
         sram_wr[sram_addr_o]  = 1'b1;
      end
   end

   // ---------------- reference model and scoreboard ----------------
   logic [7:0] ref_mem [0:1048575];

   typedef struct {
      logic        rd;
      logic [15:0] dat;
      int          lat;
      int          issue;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   wlow  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         wlow = 0;
      end else begin
         if (wb_ack_o) begin
            if (sb.size() == 0) begin
               chk("unexpected_ack", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               chk("latency", cyc - mon_e.issue, mon_e.lat);
               if (mon_e.rd) chk("rdata", int'(wb_dat_o), int'(mon_e.dat));
            end
         end
         if (!sram_we_n) begin
            chk("we_ctl", int'({sram_data_oe, sram_oe_n, sram_ce_n}), 3'b110);
            wlow++;
         end else if (wlow != 0) begin
            chk("we_low_len", wlow, W);
            wlow = 0;
         end
         if (!sram_oe_n) chk("rd_ctl", int'({sram_data_oe, sram_ce_n}), 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_req(input logic [19:1] adr, input logic we,
                         input logic [1:0] sel, input logic [15:0] dat);
      exp_t e;
      bit   got;
      @(posedge clk);
      #1;
      wb_adr_i = adr;
      wb_we_i  = we;
      wb_sel_i = sel;
      wb_dat_i = dat;
      wb_tga_i = 1'b0;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      e.rd    = ~we;
      e.issue = cyc;
      e.lat   = (sel == 2'b00) ? 1 : (int'(sel[0]) + int'(sel[1])) * (W + 1) + 1;
      e.dat   = {sel[1] ? ref_mem[{adr, 1'b1}] : 8'h00, sel[0] ? ref_mem[{adr, 1'b0}] : 8'h00};
      if (we) begin
         if (sel[0]) ref_mem[{adr, 1'b0}] = dat[7:0];
         if (sel[1]) ref_mem[{adr, 1'b1}] = dat[15:8];
      end
      sb.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (sel == 2'b00) chk("sel0_no_strobe", int'({sram_ce_n, sram_oe_n, sram_we_n}), 3'b111);
         if (wb_ack_o) got = 1'b1;
      end
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      if (!got) chk("ack_timeout", 0, 1);
   endtask

   task automatic do_tga(input int n);
      @(posedge clk);
      #1;
      wb_adr_i = 19'h091A;
      wb_we_i  = 1'b0;
      wb_sel_i = 2'b11;
      wb_tga_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      repeat (n) begin
         @(negedge clk);
         chk("tga_strobes", int'({sram_ce_n, sram_oe_n, sram_we_n}), 3'b111);
      end
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_tga_i = 1'b0;
   endtask

   // Word request whose cyc drops right after accept: low phase must finish, nothing else.
   task automatic do_abort(input logic [19:1] adr, input logic we, input logic [15:0] dat);
      @(posedge clk);
      #1;
      wb_adr_i = adr;
      wb_we_i  = we;
      wb_sel_i = 2'b11;
      wb_dat_i = dat;
      wb_tga_i = 1'b0;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      @(posedge clk);
      #1;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      if (we) ref_mem[{adr, 1'b0}] = dat[7:0];
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("abort_phase_runs", int'(sram_ce_n), 0);
      @(posedge clk);
      #1;
      chk("abort_no_hi_phase", int'(sram_ce_n), 1);
      repeat (4) @(posedge clk);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int a = 0; a < 1048576; a++) ref_mem[a] = init_byte(20'(a));
      rst      = 1'b1;
      wb_dat_i = '0;
      wb_adr_i = '0;
      wb_we_i  = 1'b0;
      wb_tga_i = 1'b0;
      wb_sel_i = '0;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack",   int'(wb_ack_o), 0);
      chk("rst_dat",   int'(wb_dat_o), 0);
      chk("rst_addr",  int'(sram_addr_o), 0);
      chk("rst_wdata", int'(sram_data_o), 0);
      chk("rst_strb",  int'({sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n}), 4'b0111);
      rst = 1'b0;

      // SRAM contents for the directed cases, loaded through the controller
      do_req(19'h091A, 1'b1, 2'b11, 16'h1234);
      // word read
      do_req(19'h091A, 1'b0, 2'b11, 16'h0000);
      // byte write to odd lane, then word read shows even byte untouched
      do_req(19'h091A, 1'b1, 2'b10, 16'hAB00);
      do_req(19'h091A, 1'b0, 2'b11, 16'h0000);
      // I/O-space cycle is ignored
      do_tga(20);
      // empty byte select
      do_req(19'h091A, 1'b0, 2'b00, 16'h0000);
      do_req(19'h091A, 1'b1, 2'b00, 16'hFFFF);

      // reset in the middle of the high phase of a word write
      @(posedge clk);
      #1;
      wb_adr_i = 19'h7FF00;
      wb_we_i  = 1'b1;
      wb_sel_i = 2'b11;
      wb_dat_i = 16'hC3C3;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("pre_rst_we_low", int'(sram_we_n), 0);
      rst      = 1'b1;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_ack",  int'(wb_ack_o), 0);
      chk("rst_mid_strb", int'({sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n}), 4'b0111);
      rst = 1'b0;
      do_req(19'h091A, 1'b0, 2'b11, 16'h0000);

      // odd-word sequence: upper byte of one word, lower byte of the next
      do_req(19'h091A, 1'b1, 2'b10, 16'h7800);
      do_req(19'h091B, 1'b1, 2'b01, 16'h0056);
      do_req(19'h091A, 1'b0, 2'b10, 16'h0000);
      do_req(19'h091B, 1'b0, 2'b01, 16'h0000);

      // aborted word write / read, then check what reached memory
      do_abort(19'h0200, 1'b1, 16'h9A5B);
      do_req(19'h0200, 1'b0, 2'b11, 16'h0000);
      do_abort(19'h0201, 1'b0, 16'h0000);
      do_req(19'h0201, 1'b0, 2'b11, 16'h0000);

      // randomized traffic over a small window so reads hit earlier writes
      for (int n = 0; n < 200; n++) begin
         int unsigned r;
         logic [19:1] a;
         r = $urandom_range(0, 11);
         a = 19'h00100 + 19'($urandom_range(0, 63));
         if (r == 0) begin
            do_tga(int'($urandom_range(2, 6)));
         end else if (r == 1) begin
            do_abort(a, 1'($urandom_range(0, 1)), 16'($urandom));
         end else begin
            do_req(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (5) @(posedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
